sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-requester SRAM controller/arbiter for the GMM background-model pipeline. Shares one asynchronous-read, synchronous-write SRAM (23-bit word address, 32-bit data, active-low ce/we/oe, bidirectional data bus) between two clients, such as the GMM parameter read/update engine and the frame pixel stream. It sequences single-word reads and writes with round-robin fairness. It inserts bus-turnaround cycles so that oe and we are never both active and the data bus never has two drivers.

## Interface
- ADDR_W, 23, SRAM word address width
- DATA_W, 32, SRAM data width
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  2  per-requester access request; held high with its command fields until granted
- req_we  in  2  per-requester command type: 1 = write, 0 = read
- req_addr  in  2*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  2*DATA_W  requester i write data in bits [i*DATA_W +: DATA_W]
- gnt  out  2  one-cycle, one-hot grant pulse; the command was accepted
- rvalid  out  2  one-cycle pulse; rdata holds that requester's read result
- rdata  out  DATA_W  read data, shared by both requesters
- sram_addr  out  ADDR_W  SRAM address
- sram_data  inout  DATA_W  SRAM data bus; driven only during a write access, Z otherwise
- sram_ce_n, sram_we_n, sram_oe_n  out  1 each  SRAM strobes, active low

## Operation
- States:
  - IDLE: no access in flight.
  - ACCESS: one SRAM cycle.
  - TURN: one dead cycle with ce_n, we_n and oe_n all at 1 and the bus at Z.
- Arbitration candidates: any requester with req=1. In ACCESS, the requester granted this cycle is masked out, because its req is still stale.
- Round-robin pick: the priority pointer favours the requester not served last. The pointer resets to favour requester 0 and updates on every grant.
- IDLE with a candidate: register the winner's command and go to ACCESS.
- ACCESS, next command selected during this cycle:
  - Same direction as the current access: go to ACCESS (back-to-back).
  - Opposite direction: go to TURN, holding the command, then ACCESS.
  - No candidate: go to IDLE.
- Read ACCESS: ce_n=0, oe_n=0, we_n=1, bus at Z. sram_data is captured into rdata at the closing edge.
- Write ACCESS: ce_n=0, we_n=0, oe_n=1, bus driven with the registered wdata. The SRAM latches at the closing edge.
- All SRAM-side outputs and the bus enable come from registers, with no combinational path from req.
- Reset values: gnt=0, rvalid=0, rdata=0, sram_addr=0, sram_ce_n=1, sram_we_n=1, sram_oe_n=1, bus at Z, state IDLE.

## Timing
- Command acceptance: a command sampled at edge E runs its ACCESS cycle between E and E+1. gnt pulses during that same cycle.
- Read latency: req sampled at E gives rvalid and rdata valid in the cycle after E+1.
- Write: committed at edge E+1.
- Throughput:
  - Alternating requesters in the same direction: 1 access per cycle.
  - A single requester streaming: 1 access per 2 cycles, because of the mask and the trip through IDLE.
  - Any read/write direction change costs one TURN cycle.
- Simultaneous requests in IDLE: the pointer decides; the loser is served next with no starvation.
- Requester behaviour after gnt: the requester may drop req, or present a new command, from the cycle after gnt onward.
- Reset mid-operation: strobes go inactive and the bus goes to Z immediately, without waiting for a clock. The in-flight access is abandoned; no gnt or rvalid is produced for it. A write is not guaranteed committed.
- Invariant, checked by assertion: never sram_we_n=0 and sram_oe_n=0 together; the bus is never driven while sram_oe_n=0.

## Structure
- Package sram_arb_pkg holds:
  - state encoding: IDLE, ACCESS, TURN;
  - default widths ADDR_W and DATA_W;
  - strobe constants STROBE_IDLE, STROBE_RD, STROBE_WR as {ce_n, we_n, oe_n} triples.
- Sub-module rr_arb2: a two-way round-robin picker.
  - Inputs: request vector, mask, pointer.
  - Outputs: one-hot winner and next pointer.
- Tri-state driver: one continuous assignment at the top level, controlled by the registered drive enable.

## Test plan
- Single read: preload SRAM[0x000010]=0xDEADBEEF, requester 0 reads 0x000010. Required: gnt[0] for 1 cycle, strobes ce_n=0/oe_n=0 for exactly 1 cycle, rvalid[0] with rdata=0xDEADBEEF one cycle later.
- Write then read: requester 1 writes 0x12345678 to 0x7FFFFF, then reads it back. Required: exactly one TURN cycle between the accesses, read returns 0x12345678, no we_n/oe_n overlap.
- Contention from reset: both requesters issue reads on the same edge. Required: gnt order 0 then 1 in consecutive cycles, with rvalid[0] and rvalid[1] on consecutive cycles. Repeat with both requesters continuously requesting: grants alternate 0,1,0,1.
- Single-requester stream: requester 0 issues 4 writes to addresses 0..3 with data 0xA0..0xA3. Required: grants 2 cycles apart; SRAM afterwards holds 0xA0..0xA3.
- Reset during a write ACCESS: assert rst_n=0 mid-cycle. Required: strobes go to 1 and the bus goes to Z without a clock edge; after release, outputs are at their reset values and a new read completes normally.
- Bus-contention monitor runs throughout: an X on sram_data while it is driven, or any we_n/oe_n overlap, fails the test.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM arbiter.
package sram_arb_pkg;

    // Default SRAM geometry: 23-bit word address, 32-bit data.
    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TURN   = 2'd2
    } state_t;

    // SRAM strobes packed as {ce_n, we_n, oe_n}, all active low.
    typedef logic [2:0] strobe_t;

    localparam strobe_t STROBE_IDLE = 3'b111;
    localparam strobe_t STROBE_RD   = 3'b010;
    localparam strobe_t STROBE_WR   = 3'b001;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin picker: masks stale requests, breaks ties with the pointer.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       ptr,
    output logic [1:0] win,
    output logic       next_ptr
);

    logic [1:0] cand;

    // Pick a one-hot winner; ptr=1 favours requester 1 on a tie.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        cand     = req & ~mask;
        win      = 2'b00;
        next_ptr = ptr;
        case (cand)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = ptr ? 2'b10 : 2'b01;
            default: win = 2'b00;
        endcase
        // After a grant, favour the requester that was not just served.
        if (win[0]) begin
            next_ptr = 1'b1;
        end else if (win[1]) begin
            next_ptr = 1'b0;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester controller for an async-read / sync-write SRAM with bus turnaround.
module sram_arbiter #(
    parameter int ADDR_W = sram_arb_pkg::ADDR_W,
    parameter int DATA_W = sram_arb_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          gnt,
    output logic [1:0]          rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]   sram_addr,
    inout  wire  [DATA_W-1:0]   sram_data,
    output logic                sram_ce_n,
    output logic                sram_we_n,
    output logic                sram_oe_n
);

    import sram_arb_pkg::*;

    typedef struct packed {
        logic              owner;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    state_t            state, state_d;
    logic              ptr, ptr_d;
    logic              owner, owner_d;
    logic              cur_we, we_d;
    cmd_t              pend, pend_d;
    logic [1:0]        gnt_d, rvalid_d;
    logic [DATA_W-1:0] rdata_d;
    logic [ADDR_W-1:0] addr_d;
    strobe_t           strobe, strobe_d;
    logic              drive_en, drive_d;
    logic [DATA_W-1:0] bus_data, bus_data_d;

    logic [1:0]        mask, win;
    logic              win_ptr;
    cmd_t              win_cmd;
    logic              launch;
    cmd_t              l_cmd;
    logic              l_ptr;

    // The requester granted in this ACCESS cycle still shows its old req.
    assign mask = (state == ACCESS) ? gnt : 2'b00;

    rr_arb2 u_rr (
        .req      (req),
        .mask     (mask),
        .ptr      (ptr),
        .win      (win),
        .next_ptr (win_ptr)
    );

    // Gather the winning requester's command fields.
    always_comb begin
        win_cmd.owner = win[1];
        win_cmd.we    = win[1] ? req_we[1] : req_we[0];
        win_cmd.addr  = win[1] ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        win_cmd.wdata = win[1] ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    end

    // Next-state and next-output decode; every SRAM-side output is registered below.
    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        owner_d    = owner;
        we_d       = cur_we;
        pend_d     = pend;
        gnt_d      = 2'b00;
        rvalid_d   = 2'b00;
        rdata_d    = rdata;
        addr_d     = sram_addr;
        strobe_d   = STROBE_IDLE;
        drive_d    = 1'b0;
        bus_data_d = bus_data;
        launch     = 1'b0;
        l_cmd      = pend;
        l_ptr      = ~pend.owner;

        // A read ACCESS closes by capturing the bus for its owner.
        if (state == ACCESS && !cur_we) begin
            rvalid_d[owner] = 1'b1;
            rdata_d         = sram_data;
        end

        case (state)
            IDLE: begin
                if (|win) begin
                    launch = 1'b1;
                    l_cmd  = win_cmd;
                    l_ptr  = win_ptr;
                end
            end
            ACCESS: begin
                if (!(|win)) begin
                    state_d = IDLE;
                end else if (win_cmd.we == cur_we) begin
                    launch = 1'b1;
                    l_cmd  = win_cmd;
                    l_ptr  = win_ptr;
                end else begin
                    // Direction change: park the command behind one dead cycle.
                    state_d = TURN;
                    pend_d  = win_cmd;
                end
            end
            TURN: begin
                launch = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d          = ACCESS;
            ptr_d            = l_ptr;
            owner_d          = l_cmd.owner;
            we_d             = l_cmd.we;
            gnt_d[l_cmd.owner] = 1'b1;
            addr_d           = l_cmd.addr;
            strobe_d         = l_cmd.we ? STROBE_WR : STROBE_RD;
            drive_d          = l_cmd.we;
            bus_data_d       = l_cmd.wdata;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= state_d;
        end
    end

    // Datapath and SRAM-side output registers; async reset idles the bus immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= 1'b0;
            owner     <= 1'b0;
            cur_we    <= 1'b0;
            pend      <= '0;
            gnt       <= 2'b00;
            rvalid    <= 2'b00;
            rdata     <= '0;
            sram_addr <= '0;
            strobe    <= STROBE_IDLE;
            drive_en  <= 1'b0;
            bus_data  <= '0;
        end else begin
            ptr       <= ptr_d;
            owner     <= owner_d;
            cur_we    <= we_d;
            pend      <= pend_d;
            gnt       <= gnt_d;
            rvalid    <= rvalid_d;
            rdata     <= rdata_d;
            sram_addr <= addr_d;
            strobe    <= strobe_d;
            drive_en  <= drive_d;
            bus_data  <= bus_data_d;
        end
    end

    assign {sram_ce_n, sram_we_n, sram_oe_n} = strobe;

    // Single tri-state driver for the shared data bus.
    assign sram_data = drive_en ? bus_data : {DATA_W{1'bz}};

    // oe and we never overlap, and the bus is never driven while the SRAM outputs.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(!sram_we_n && !sram_oe_n) && !(drive_en && !sram_oe_n));

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async-read / sync-write SRAM.
module tb_sram_arbiter;

    localparam logic [2:0] S_IDLE = 3'b111;
    localparam logic [2:0] S_RD   = 3'b010;
    localparam logic [2:0] S_WR   = 3'b001;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  req_we;
    logic [45:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata;
    logic [22:0] sram_addr;
    wire  [31:0] sram_data;
    logic        sram_ce_n, sram_we_n, sram_oe_n;

    int total;
    int passed;
    int cyc;

    sram_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_ce_n (sram_ce_n),
        .sram_we_n (sram_we_n),
        .sram_oe_n (sram_oe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: decodes the low 8 address bits (every test address is distinct there).
    logic [31:0] mem [0:255];
    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;
    logic        mem_rd;

    assign mem_rd    = !sram_ce_n && !sram_oe_n && sram_we_n;
    assign sram_data = mem_rd ? mem[sram_addr[7:0]] : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (!sram_ce_n && !sram_we_n) begin
            mem[sram_addr[7:0]] <= sram_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            passed = passed + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_en   = 1'b0;
    endtask

    // Bus-contention monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            check("we_oe_overlap", {31'd0, !sram_we_n && !sram_oe_n}, 32'd0);
            check("bus_x_when_driven", {31'd0, !sram_we_n && $isunknown(sram_data)}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [22:0] a0;
        logic [31:0] d0;
        logic [22:0] a1;
        logic [31:0] d1;
        logic [1:0]  gnt;
        logic [1:0]  rvalid;
        logic [31:0] rdata;
        logic [2:0]  strb;
        logic [22:0] addr;
        logic        chk_addr;
    } vec_t;

    function automatic vec_t mk(
        logic [1:0] rq, logic [1:0] we, logic [22:0] a0, logic [31:0] d0,
        logic [22:0] a1, logic [31:0] d1, logic [1:0] g, logic [1:0] rv,
        logic [31:0] rd, logic [2:0] s, logic [22:0] ad, logic ca);
        vec_t v;
        v.req = rq; v.we = we; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.strb = s; v.addr = ad; v.chk_addr = ca;
        return v;
    endfunction

    vec_t tbl [11];

    initial begin
        logic        seen;
        int          last;
        logic [1:0]  eg, ev;
        logic [31:0] er;

        total = 0; passed = 0;
        rst_n = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        #2 rst_n = 1'b0;

        preload(8'h10, 32'hDEAD_BEEF);
        preload(8'h20, 32'h1111_1111);
        preload(8'h21, 32'h2222_2222);

        check("reset strobes", {29'd0, sram_ce_n, sram_we_n, sram_oe_n}, {29'd0, S_IDLE});
        check("reset gnt", {30'd0, gnt}, 32'd0);
        check("reset rvalid", {30'd0, rvalid}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset addr", {9'd0, sram_addr}, 32'd0);
        check("reset bus enable", {31'd0, dut.drive_en}, 32'd0);

        @(negedge clk) rst_n = 1'b1;
        tick();

        // Single read, write/read by requester 1, then a write->read direction change with TURN.
        tbl[0]  = mk(2'b01, 2'b00, 23'h10, 0, 0, 0,                    2'b01, 2'b00, 32'h0,         S_RD,   23'h10,     1);
        tbl[1]  = mk(2'b00, 2'b00, 0, 0, 0, 0,                         2'b00, 2'b01, 32'hDEAD_BEEF, S_IDLE, 0,          0);
        tbl[2]  = mk(2'b00, 2'b00, 0, 0, 0, 0,                         2'b00, 2'b00, 32'hDEAD_BEEF, S_IDLE, 0,          0);
        tbl[3]  = mk(2'b10, 2'b10, 0, 0, 23'h7FFFFF, 32'h1234_5678,    2'b10, 2'b00, 32'hDEAD_BEEF, S_WR,   23'h7FFFFF, 1);
        tbl[4]  = mk(2'b10, 2'b00, 0, 0, 23'h7FFFFF, 0,                2'b00, 2'b00, 32'hDEAD_BEEF, S_IDLE, 0,          0);
        tbl[5]  = mk(2'b10, 2'b00, 0, 0, 23'h7FFFFF, 0,                2'b10, 2'b00, 32'hDEAD_BEEF, S_RD,   23'h7FFFFF, 1);
        tbl[6]  = mk(2'b00, 2'b00, 0, 0, 0, 0,                         2'b00, 2'b10, 32'h1234_5678, S_IDLE, 0,          0);
        tbl[7]  = mk(2'b11, 2'b01, 23'h5, 32'h55, 23'h7FFFFF, 0,       2'b01, 2'b00, 32'h1234_5678, S_WR,   23'h5,      1);
        tbl[8]  = mk(2'b10, 2'b00, 0, 0, 23'h7FFFFF, 0,                2'b00, 2'b00, 32'h1234_5678, S_IDLE, 0,          0);
        tbl[9]  = mk(2'b10, 2'b00, 0, 0, 23'h7FFFFF, 0,                2'b10, 2'b00, 32'h1234_5678, S_RD,   23'h7FFFFF, 1);
        tbl[10] = mk(2'b00, 2'b00, 0, 0, 0, 0,                         2'b00, 2'b10, 32'h1234_5678, S_IDLE, 0,          0);

        for (int i = 0; i < 11; i++) begin
            req       = tbl[i].req;
            req_we    = tbl[i].we;
            req_addr  = {tbl[i].a1, tbl[i].a0};
            req_wdata = {tbl[i].d1, tbl[i].d0};
            tick();
            check($sformatf("vec%0d gnt", i), {30'd0, gnt}, {30'd0, tbl[i].gnt});
            check($sformatf("vec%0d rvalid", i), {30'd0, rvalid}, {30'd0, tbl[i].rvalid});
            check($sformatf("vec%0d rdata", i), rdata, tbl[i].rdata);
            check($sformatf("vec%0d strobes", i), {29'd0, sram_ce_n, sram_we_n, sram_oe_n}, {29'd0, tbl[i].strb});
            if (tbl[i].chk_addr) begin
                check($sformatf("vec%0d addr", i), {9'd0, sram_addr}, {9'd0, tbl[i].addr});
            end
        end
        check("mem[0x7FFFFF]", mem[8'hFF], 32'h1234_5678);
        check("mem[0x5]", mem[8'h05], 32'h0000_0055);

        // Contention from reset: both read continuously, grants alternate 0,1,0,1.
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        req       = 2'b11;
        req_we    = 2'b00;
        req_addr  = {23'h21, 23'h20};
        req_wdata = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            ev = (i == 0) ? 2'b00 : ((i % 2 == 1) ? 2'b01 : 2'b10);
            er = (i == 0) ? 32'h0 : ((i % 2 == 1) ? 32'h1111_1111 : 32'h2222_2222);
            check($sformatf("contend%0d gnt", i), {30'd0, gnt}, {30'd0, eg});
            check($sformatf("contend%0d rvalid", i), {30'd0, rvalid}, {30'd0, ev});
            check($sformatf("contend%0d rdata", i), rdata, er);
        end
        req = 2'b00;
        tick();
        check("contend tail rvalid", {30'd0, rvalid}, 32'd2);
        tick();

        // Single-requester write stream: grants two cycles apart.
        last = 0;
        for (int k = 0; k < 4; k++) begin
            req       = 2'b01;
            req_we    = 2'b01;
            req_addr  = {23'd0, 23'(k)};
            req_wdata = {32'd0, 32'hA0 + 32'(k)};
            seen      = 1'b0;
            for (int n = 0; n < 8 && !seen; n++) begin
                tick();
                if (gnt[0]) seen = 1'b1;
            end
            check($sformatf("stream%0d gnt seen", k), {31'd0, seen}, 32'd1);
            if (k > 0) begin
                check($sformatf("stream%0d gnt spacing", k), 32'(cyc - last), 32'd2);
            end
            last = cyc;
            tick();
        end
        req = 2'b00;
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("stream mem[%0d]", k), mem[8'(k)], 32'hA0 + 32'(k));
        end

        // Reset in the middle of a write ACCESS.
        req       = 2'b01;
        req_we    = 2'b01;
        req_addr  = {23'd0, 23'h30};
        req_wdata = {32'd0, 32'h99};
        tick();
        check("rstmid write gnt", {30'd0, gnt}, 32'd1);
        check("rstmid write strobes", {29'd0, sram_ce_n, sram_we_n, sram_oe_n}, {29'd0, S_WR});
        #2 rst_n = 1'b0;
        #1;
        check("rstmid strobes async", {29'd0, sram_ce_n, sram_we_n, sram_oe_n}, {29'd0, S_IDLE});
        check("rstmid bus enable async", {31'd0, dut.drive_en}, 32'd0);
        req = 2'b00;
        tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("post-rst gnt", {30'd0, gnt}, 32'd0);
        check("post-rst rvalid", {30'd0, rvalid}, 32'd0);
        check("post-rst rdata", rdata, 32'd0);
        check("post-rst addr", {9'd0, sram_addr}, 32'd0);
        check("post-rst strobes", {29'd0, sram_ce_n, sram_we_n, sram_oe_n}, {29'd0, S_IDLE});
        req       = 2'b01;
        req_we    = 2'b00;
        req_addr  = {23'd0, 23'h10};
        tick();
        check("post-rst read gnt", {30'd0, gnt}, 32'd1);
        req = 2'b00;
        tick();
        check("post-rst read rvalid", {30'd0, rvalid}, 32'd1);
        check("post-rst read rdata", rdata, 32'hDEAD_BEEF);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
